// File: rtl/decode_issue.sv
// decode_issue: RV32I decode stage feeding a one-entry issue register (EMPTY/FULL).
// Define DECODE_ISSUE_SCOREBOARD_EN to add the pending-write hazard scoreboard.
module decode_issue (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        InstrValid,
    input  logic [31:0] Instr,
    input  logic [31:0] PCIn,
    output logic        InstrReady,
    output logic        IssueValid,
    input  logic        IssueReady,
    output logic [31:0] A1,
    output logic [31:0] A2,
    output logic [31:0] A3,
    output logic        RegWrite,
    output logic [31:0] Imm,
    output logic [31:0] PCOut,
    output logic [2:0]  Funct3,
    output logic        Funct7b5,
    output logic [3:0]  OpClass,
    output logic        Illegal,
    input  logic        WbValid,
    input  logic [4:0]  WbRd
);

    typedef enum logic [3:0] {
        OC_R      = 4'd0,
        OC_IALU   = 4'd1,
        OC_LOAD   = 4'd2,
        OC_STORE  = 4'd3,
        OC_BRANCH = 4'd4,
        OC_LUI    = 4'd5,
        OC_AUIPC  = 4'd6,
        OC_JAL    = 4'd7,
        OC_JALR   = 4'd8,
        OC_ILLEGAL = 4'd15
    } op_class_e;

    typedef enum logic { S_EMPTY, S_FULL } issue_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        reg_write;
        logic [2:0]  funct3;
        logic        funct7b5;
        op_class_e   op_class;
        logic        illegal;
    } issue_t;

    op_class_e    op_class;
    logic         use_rs1;
    logic         use_rs2;
    logic         use_rd;
    issue_t       dec;
    issue_t       issue_d;
    issue_t       issue_q;
    issue_state_e state_d;
    issue_state_e state_q;
    logic         hazard;
    logic         accept;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        op_class = OC_ILLEGAL;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        case (Instr[6:0])
            7'b0110011: begin op_class = OC_R;      use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            7'b0010011: begin op_class = OC_IALU;   use_rs1 = 1'b1; use_rd = 1'b1; end
            7'b0000011: begin op_class = OC_LOAD;   use_rs1 = 1'b1; use_rd = 1'b1; end
            7'b0100011: begin op_class = OC_STORE;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b1100011: begin op_class = OC_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0110111: begin op_class = OC_LUI;    use_rd = 1'b1; end
            7'b0010111: begin op_class = OC_AUIPC;  use_rd = 1'b1; end
            7'b1101111: begin op_class = OC_JAL;    use_rd = 1'b1; end
            7'b1100111: begin op_class = OC_JALR;   use_rs1 = 1'b1; use_rd = 1'b1; end
            default:    op_class = OC_ILLEGAL;
        endcase
    end

    always_comb begin
        dec           = '0;
        dec.pc        = PCIn;
        dec.funct3    = Instr[14:12];
        dec.funct7b5  = Instr[30];
        dec.op_class  = op_class;
        dec.illegal   = (op_class == OC_ILLEGAL);
        dec.a1        = use_rs1 ? Instr[19:15] : 5'd0;
        dec.a2        = use_rs2 ? Instr[24:20] : 5'd0;
        dec.a3        = use_rd  ? Instr[11:7]  : 5'd0;
        dec.reg_write = use_rd && (Instr[11:7] != 5'd0);
        case (op_class)
            OC_IALU, OC_LOAD, OC_JALR: dec.imm = {{20{Instr[31]}}, Instr[31:20]};
            OC_STORE:  dec.imm = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
            OC_BRANCH: dec.imm = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            OC_LUI, OC_AUIPC: dec.imm = {Instr[31:12], 12'd0};
            OC_JAL:    dec.imm = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            default:   dec.imm = 32'd0;
        endcase
    end

`ifdef DECODE_ISSUE_SCOREBOARD_EN
    logic [31:0] pending_d;
    logic [31:0] pending_q;

    // Unused source/dest fields decode to index 0, which never holds a pending write.
    always_comb begin
        hazard = pending_q[dec.a1] || pending_q[dec.a2] || (dec.reg_write && pending_q[dec.a3]);
    end

    always_comb begin
        pending_d = pending_q;
        if (WbValid) pending_d[WbRd] = 1'b0;
        if (accept && dec.reg_write) pending_d[dec.a3] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{WbValid, WbRd};
    assign hazard    = 1'b0;
`endif

    assign IssueValid = (state_q == S_FULL);
    assign InstrReady = (!IssueValid || IssueReady) && !hazard;
    assign accept     = InstrValid && InstrReady;

    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        if (accept) begin
            state_d = S_FULL;
            issue_d = dec;
        end else if (IssueReady) begin
            state_d = S_EMPTY;
        end
    end

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_EMPTY;
            issue_q <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
        end
    end

    assign A1       = {27'd0, issue_q.a1};
    assign A2       = {27'd0, issue_q.a2};
    assign A3       = {27'd0, issue_q.a3};
    assign RegWrite = issue_q.reg_write;
    assign Imm      = issue_q.imm;
    assign PCOut    = issue_q.pc;
    assign Funct3   = issue_q.funct3;
    assign Funct7b5 = issue_q.funct7b5;
    assign OpClass  = issue_q.op_class;
    assign Illegal  = issue_q.illegal;

endmodule
